obi_tcdm_rid_tracker: RTL and testbench
=======================================

// Module: obi_tcdm_rid_tracker
// PURPOSE
//  Sits directly upstream of the OBI-to-TCDM converter, one instance per channel.
//  TCDM responses carry no ID, so this block records the OBI aid of every
//  granted request in an in-order FIFO and returns it as rid with the matching
//  response.
//  Caps outstanding transactions at MaxTrans by gating req/gnt, optionally
//  registers the response path, and flags responses that arrive with nothing
//  outstanding.
// PARAMETERS
//  IdWidth    4   width of OBI aid/rid
//  DataWidth  32  width of rdata
//  MaxTrans   4   max outstanding granted-but-unanswered requests (>=1, any value)
//  RspReg     1   1: response path registered (+1 cycle); 0: combinational pass
// PORTS
//  clk_i          in   1                    clock
//  rst_ni         in   1                    async reset, active low
//  up_req_i       in   1                    OBI req from master
//  up_aid_i       in   IdWidth              OBI aid, sampled on up_req_i&up_gnt_o
//  up_gnt_o       out  1                    OBI gnt to master
//  up_rvalid_o    out  1                    OBI rvalid to master
//  up_rid_o       out  IdWidth              aid of oldest outstanding request
//  up_rdata_o     out  DataWidth            response data
//  dn_req_o       out  1                    req to OBI-to-TCDM converter
//  dn_gnt_i       in   1                    gnt from converter (TCDM q_ready)
//  dn_rvalid_i    in   1                    rvalid from converter (TCDM p_valid)
//  dn_rdata_i     in   DataWidth            rdata from converter
//  outstanding_o  out  $clog2(MaxTrans+1)   current FIFO occupancy
//  spurious_o     out  1                    sticky: response seen with FIFO empty
// BEHAVIOUR
//  - addr/we/be/wdata bypass this block; only req/gnt/r-channel pass through.
//  - full = (count==MaxTrans); empty = (count==0).
//  - dn_req_o = up_req_i & ~full; up_gnt_o = dn_gnt_i & ~full.
//  - gnt never depends combinationally on dn_rvalid_i.
//  - push: up_req_i & up_gnt_o -> aid written at wptr, wptr++.
//  - pop: dn_rvalid_i & ~empty -> rptr++.
//  - count: +1 on push only, -1 on pop only, unchanged on both.
//  - Pointers wrap MaxTrans-1 -> 0 explicitly; MaxTrans need not be a power of 2.
//  - Full: push blocked even if a pop occurs the same cycle (conservative).
//    The grant reappears the cycle after count drops.
//  - Empty + dn_rvalid_i: response dropped (no up_rvalid_o), spurious_o set.
//    spurious_o clears only on reset. A same-cycle push does not satisfy it:
//    TCDM latency is >= 1 cycle.
//  - RspReg=0:
//    - up_rvalid_o = dn_rvalid_i & ~empty; up_rid_o = fifo[rptr];
//      up_rdata_o = dn_rdata_i.
//    - Req-to-rvalid latency is the TCDM latency.
//  - RspReg=1:
//    - up_rvalid_o/up_rid_o/up_rdata_o registered from the above values.
//    - Adds exactly 1 cycle; rvalid is 0 on idle cycles.
//    - rid/rdata hold their last value while rvalid is low.
//  - Ordering: responses are strictly in grant order; no reordering.
//  - No backpressure on responses (OBI without rready): every non-spurious
//    dn_rvalid_i produces exactly one up_rvalid_o.
//  - Reset (async assert, sync deassert expected from the reset tree):
//    - count, wptr and rptr are 0; up_rvalid_o, up_rid_o and up_rdata_o are 0;
//      spurious_o is 0.
//    - up_gnt_o/dn_req_o follow their inputs (not full).
//  - Reset mid-operation: in-flight aids are discarded. Responses arriving
//    after reset are treated as spurious.
// TESTING
//  1. MaxTrans=4, RspReg=0: 4 grants aid 1,2,3,4, no rsp.
//     -> 5th req: dn_req_o=0, up_gnt_o=0, outstanding_o=4.
//  2. From 1: one dn_rvalid_i with rdata 0xCAFE0001.
//     -> same cycle rvalid=1, rid=1, rdata=0xCAFE0001.
//     -> next cycle gnt reopens and outstanding_o=3.
//  3. RspReg=1: back-to-back grants aid 5,9, TCDM latency 1.
//     -> up_rvalid_o 2 cycles after each grant, rid 5 then 9.
//  4. Full with simultaneous pop and req.
//     -> no grant that cycle, count 4->3, grant the following cycle.
//  5. Idle, dn_rvalid_i=1 with count=0.
//     -> up_rvalid_o stays 0, spurious_o=1 and stays 1 until rst_ni low.
//  6. MaxTrans=3: 7 push/pop pairs with aid 0..6.
//     -> rids 0..6 in order, pointers wrap at 2->0.
//  7. Assert rst_ni low with 2 outstanding.
//     -> outstanding_o=0, outputs 0.
//     -> a later dn_rvalid_i sets spurious_o.

Source files
------------

// File: rtl/obi_tcdm_rid_tracker.sv
// Returns the OBI aid of each granted request as rid on its (in-order) TCDM response,
// caps outstanding transactions at MaxTrans and flags responses with nothing outstanding.
module obi_tcdm_rid_tracker #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 4,
  parameter bit          RspReg    = 1'b1,
  localparam int unsigned CntW     = $clog2(MaxTrans + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 up_req_i,
  input  logic [IdWidth-1:0]   up_aid_i,
  output logic                 up_gnt_o,
  output logic                 up_rvalid_o,
  output logic [IdWidth-1:0]   up_rid_o,
  output logic [DataWidth-1:0] up_rdata_o,
  output logic                 dn_req_o,
  input  logic                 dn_gnt_i,
  input  logic                 dn_rvalid_i,
  input  logic [DataWidth-1:0] dn_rdata_i,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 spurious_o
);

  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

  logic [MaxTrans-1:0][IdWidth-1:0] fifo_q;
  logic [PtrW-1:0]                  wptr_q, rptr_q;
  logic [CntW-1:0]                  cnt_q;
  logic                             spur_q;
  logic                             full, empty, push, pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full     = (cnt_q == CntW'(MaxTrans));
  assign empty    = (cnt_q == '0);
  // Full blocks the grant even on a same-cycle pop, keeping gnt off the rvalid path.
  assign dn_req_o = up_req_i & ~full;
  assign up_gnt_o = dn_gnt_i & ~full;
  assign push     = up_req_i & up_gnt_o;
  assign pop      = dn_rvalid_i & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      spur_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= up_aid_i;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (dn_rvalid_i && empty) spur_q <= 1'b1;
    end
  end

  assign outstanding_o = cnt_q;
  assign spurious_o    = spur_q;

  generate
    if (RspReg) begin : g_rsp_reg
      logic                 rvalid_q;
      logic [IdWidth-1:0]   rid_q;
      logic [DataWidth-1:0] rdata_q;

      // rid/rdata only load on a live response so they hold while rvalid is low.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rvalid_q <= 1'b0;
          rid_q    <= '0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= pop;
          if (pop) begin
            rid_q   <= fifo_q[rptr_q];
            rdata_q <= dn_rdata_i;
          end
        end
      end

      assign up_rvalid_o = rvalid_q;
      assign up_rid_o    = rid_q;
      assign up_rdata_o  = rdata_q;
    end else begin : g_rsp_comb
      assign up_rvalid_o = pop;
      assign up_rid_o    = fifo_q[rptr_q];
      assign up_rdata_o  = dn_rdata_i;
    end
  endgenerate

endmodule

// File: tb/tb_obi_tcdm_rid_tracker.sv
// Three tracker instances (depth 4 comb, depth 4 registered, depth 3 comb) share one
// stimulus stream; directed scenarios plus random traffic against a queue-based model.
module tb_obi_tcdm_rid_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        up_req, dn_gnt, dn_rvalid;
  logic [3:0]  up_aid;
  logic [31:0] dn_rdata;

  logic [2:0]  gnt_a, req_a, rv_a, spur_a;
  logic [3:0]  rid0, rid1, rid2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [2:0]  cnt0, cnt1;
  logic [1:0]  cnt2;
  logic [3:0]  rid_a   [3];
  logic [31:0] rdata_a [3];
  logic [2:0]  cnt_a   [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rid_a[0] = rid0;     assign rid_a[1] = rid1;     assign rid_a[2] = rid2;
  assign rdata_a[0] = rdata0; assign rdata_a[1] = rdata1; assign rdata_a[2] = rdata2;
  assign cnt_a[0] = cnt0;     assign cnt_a[1] = cnt1;     assign cnt_a[2] = {1'b0, cnt2};

  obi_tcdm_rid_tracker #(.IdWidth(4), .DataWidth(32), .MaxTrans(4), .RspReg(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .up_req_i(up_req), .up_aid_i(up_aid), .up_gnt_o(gnt_a[0]),
    .up_rvalid_o(rv_a[0]), .up_rid_o(rid0), .up_rdata_o(rdata0), .dn_req_o(req_a[0]),
    .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata),
    .outstanding_o(cnt0), .spurious_o(spur_a[0]));

  obi_tcdm_rid_tracker #(.IdWidth(4), .DataWidth(32), .MaxTrans(4), .RspReg(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .up_req_i(up_req), .up_aid_i(up_aid), .up_gnt_o(gnt_a[1]),
    .up_rvalid_o(rv_a[1]), .up_rid_o(rid1), .up_rdata_o(rdata1), .dn_req_o(req_a[1]),
    .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata),
    .outstanding_o(cnt1), .spurious_o(spur_a[1]));

  obi_tcdm_rid_tracker #(.IdWidth(4), .DataWidth(32), .MaxTrans(3), .RspReg(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .up_req_i(up_req), .up_aid_i(up_aid), .up_gnt_o(gnt_a[2]),
    .up_rvalid_o(rv_a[2]), .up_rid_o(rid2), .up_rdata_o(rdata2), .dn_req_o(req_a[2]),
    .dn_gnt_i(dn_gnt), .dn_rvalid_i(dn_rvalid), .dn_rdata_i(dn_rdata),
    .outstanding_o(cnt2), .spurious_o(spur_a[2]));

  // Reference model: per instance, a queue of granted aids in grant order.
  int          mt [3] = '{4, 4, 3};
  bit          rr [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0]  mq [3][$];
  bit          mspur [3];
  bit          mrv   [3];
  logic [3:0]  mrid  [3];
  logic [31:0] mrdata[3];
  bit          c_rv  [3];
  logic        e_gnt [3], e_req [3], e_rv [3];
  logic [3:0]  e_rid [3];
  logic [31:0] e_rdata [3];
  int          e_cnt [3];

  function automatic void model_clear();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mspur[k] = 1'b0; mrv[k] = 1'b0; mrid[k] = '0; mrdata[k] = '0;
    end
  endfunction

  function automatic void model_eval();
    for (int k = 0; k < 3; k++) begin
      bit full;
      full     = (mq[k].size() == mt[k]);
      e_req[k] = up_req && !full;
      e_gnt[k] = dn_gnt && !full;
      c_rv[k]  = dn_rvalid && (mq[k].size() != 0);
      e_cnt[k] = mq[k].size();
      if (rr[k]) begin
        e_rv[k] = mrv[k]; e_rid[k] = mrid[k]; e_rdata[k] = mrdata[k];
      end else begin
        e_rv[k]    = c_rv[k];
        e_rid[k]   = (mq[k].size() != 0) ? mq[k][0] : 4'h0;
        e_rdata[k] = dn_rdata;
      end
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      if (dn_rvalid && mq[k].size() == 0) mspur[k] = 1'b1;
      if (rr[k]) begin
        mrv[k] = c_rv[k];
        if (c_rv[k]) begin mrid[k] = mq[k][0]; mrdata[k] = dn_rdata; end
      end
      if (c_rv[k]) void'(mq[k].pop_front());
      if (up_req && e_gnt[k]) mq[k].push_back(up_aid);
    end
  endfunction

  task automatic idle_inputs();
    up_req = 1'b0; up_aid = '0; dn_gnt = 1'b0; dn_rvalid = 1'b0; dn_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n  = 1'b0;
    up_req = 1'b1;
    dn_gnt = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({rv_a[k], spur_a[k], cnt_a[k], rid_a[k], rdata_a[k]} !== '0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: rv=%b spur=%b cnt=%0d rid=%h rdata=%h, all must be 0",
                 k, rv_a[k], spur_a[k], cnt_a[k], rid_a[k], rdata_a[k]);
      end
      n_chk++;
      if ({gnt_a[k], req_a[k]} !== 2'b11) begin
        n_fail++;
        $display("FAIL reset_passthru[%0d]: gnt=%b req=%b exp 1 1", k, gnt_a[k], req_a[k]);
      end
    end
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_fill_and_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      up_req = 1'b1; up_aid = 4'(i); dn_gnt = 1'b1;
      @(negedge clk);
      n_chk++;
      if (gnt_a[0] !== 1'b1) begin n_fail++; $display("FAIL fill_gnt%0d: got %b exp 1", i, gnt_a[0]); end
      next_cycle();
    end
    @(negedge clk);
    n_chk++;
    if ({req_a[0], gnt_a[0], cnt0} !== {2'b00, 3'd4}) begin
      n_fail++;
      $display("FAIL full_block: req=%b gnt=%b cnt=%0d exp 0 0 4", req_a[0], gnt_a[0], cnt0);
    end
    next_cycle();
    up_aid = 4'd5; dn_rvalid = 1'b1; dn_rdata = 32'hCAFE0001;
    @(negedge clk);
    n_chk++;
    if ({rv_a[0], rid0, rdata0, gnt_a[0]} !== {1'b1, 4'd1, 32'hCAFE0001, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_rsp: rv=%b rid=%h rdata=%h gnt=%b exp 1 1 cafe0001 0",
               rv_a[0], rid0, rdata0, gnt_a[0]);
    end
    next_cycle();
    up_req = 1'b0; dn_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({gnt_a[0], cnt0} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL drain_reopen: gnt=%b cnt=%0d exp 1 3", gnt_a[0], cnt0);
    end
    n_chk++;
    if ({rv_a[1], rid1, rdata1} !== {1'b1, 4'd1, 32'hCAFE0001}) begin
      n_fail++;
      $display("FAIL drain_reg_rsp: rv=%b rid=%h rdata=%h exp 1 1 cafe0001", rv_a[1], rid1, rdata1);
    end
  endtask

  task automatic test_back_to_back_rspreg();
    do_reset();
    up_req = 1'b1; up_aid = 4'd5; dn_gnt = 1'b1;
    @(negedge clk);
    n_chk++;
    if (rv_a[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_idle0: rv=%b exp 0", rv_a[1]); end
    next_cycle();
    up_aid = 4'd9; dn_rvalid = 1'b1; dn_rdata = 32'h000D0005;
    @(negedge clk);
    n_chk++;
    if ({rv_a[1], rv_a[0], rid0} !== {1'b0, 1'b1, 4'd5}) begin
      n_fail++;
      $display("FAIL b2b_lat: regrv=%b combrv=%b combrid=%h exp 0 1 5", rv_a[1], rv_a[0], rid0);
    end
    next_cycle();
    up_req = 1'b0; dn_rdata = 32'h000D0009;
    @(negedge clk);
    n_chk++;
    if ({rv_a[1], rid1, rdata1} !== {1'b1, 4'd5, 32'h000D0005}) begin
      n_fail++;
      $display("FAIL b2b_rsp5: rv=%b rid=%h rdata=%h exp 1 5 000d0005", rv_a[1], rid1, rdata1);
    end
    next_cycle();
    dn_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({rv_a[1], rid1, rdata1} !== {1'b1, 4'd9, 32'h000D0009}) begin
      n_fail++;
      $display("FAIL b2b_rsp9: rv=%b rid=%h rdata=%h exp 1 9 000d0009", rv_a[1], rid1, rdata1);
    end
    next_cycle();
    @(negedge clk);
    n_chk++;
    if ({rv_a[1], rid1, rdata1} !== {1'b0, 4'd9, 32'h000D0009}) begin
      n_fail++;
      $display("FAIL b2b_hold: rv=%b rid=%h rdata=%h exp 0 9 000d0009", rv_a[1], rid1, rdata1);
    end
  endtask

  task automatic test_full_simul_pop();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      up_req = 1'b1; up_aid = 4'(i); dn_gnt = 1'b1;
      next_cycle();
    end
    up_aid = 4'd7; dn_rvalid = 1'b1; dn_rdata = 32'h11;
    @(negedge clk);
    n_chk++;
    if ({gnt_a[0], req_a[0], rv_a[0], rid0, cnt0} !== {3'b001, 4'd1, 3'd4}) begin
      n_fail++;
      $display("FAIL fullpop_same: gnt=%b req=%b rv=%b rid=%h cnt=%0d exp 0 0 1 1 4",
               gnt_a[0], req_a[0], rv_a[0], rid0, cnt0);
    end
    next_cycle();
    dn_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({gnt_a[0], cnt0} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL fullpop_next: gnt=%b cnt=%0d exp 1 3", gnt_a[0], cnt0);
    end
    next_cycle();
    up_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({gnt_a[0], cnt0} !== {1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL fullpop_refill: gnt=%b cnt=%0d exp 0 4", gnt_a[0], cnt0);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    dn_rvalid = 1'b1; dn_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    n_chk++;
    if (rv_a !== 3'b000) begin n_fail++; $display("FAIL spur_drop: rv=%b exp 000", rv_a); end
    next_cycle();
    dn_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({spur_a, rv_a} !== 6'b111_000) begin
      n_fail++;
      $display("FAIL spur_set: spur=%b rv=%b exp 111 000", spur_a, rv_a);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    n_chk++;
    if (spur_a !== 3'b111) begin n_fail++; $display("FAIL spur_sticky: spur=%b exp 111", spur_a); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (spur_a !== 3'b000) begin n_fail++; $display("FAIL spur_clear: spur=%b exp 000", spur_a); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i <= 7; i++) begin
      up_req = (i < 7); up_aid = 4'(i); dn_gnt = 1'b1;
      dn_rvalid = (i > 0); dn_rdata = 32'hA0 + 32'(i) - 32'd1;
      @(negedge clk);
      if (i > 0) begin
        n_chk++;
        if ({rv_a[2], rid2, rdata2, cnt2} !== {1'b1, 4'(i - 1), 32'hA0 + 32'(i) - 32'd1, 2'd1}) begin
          n_fail++;
          $display("FAIL wrap_rsp%0d: rv=%b rid=%h rdata=%h cnt=%0d exp 1 %0d %h 1",
                   i, rv_a[2], rid2, rdata2, cnt2, i - 1, 32'hA0 + 32'(i) - 32'd1);
        end
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL wrap_empty: cnt=%0d exp 0", cnt2); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 3; i <= 4; i++) begin
      up_req = 1'b1; up_aid = 4'(i); dn_gnt = 1'b1;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_chk++;
    if (cnt0 !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre: cnt=%0d exp 2", cnt0); end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({rv_a[k], spur_a[k], cnt_a[k], rid_a[k], rdata_a[k]} !== '0) begin
        n_fail++;
        $display("FAIL rstmid_clear[%0d]: rv=%b spur=%b cnt=%0d rid=%h rdata=%h, all must be 0",
                 k, rv_a[k], spur_a[k], cnt_a[k], rid_a[k], rdata_a[k]);
      end
    end
    next_cycle();
    rst_n = 1'b1; dn_rvalid = 1'b1; dn_rdata = 32'h5;
    @(negedge clk);
    n_chk++;
    if (rv_a !== 3'b000) begin n_fail++; $display("FAIL rstmid_drop: rv=%b exp 000", rv_a); end
    next_cycle();
    dn_rvalid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (spur_a !== 3'b111) begin n_fail++; $display("FAIL rstmid_spur: spur=%b exp 111", spur_a); end
  endtask

  task automatic test_random();
    do_reset();
    model_clear();
    for (int c = 0; c < 400; c++) begin
      up_req    = 1'($urandom_range(0, 1));
      up_aid    = 4'($urandom);
      dn_gnt    = ($urandom_range(0, 3) != 0);
      dn_rvalid = ($urandom_range(0, 9) < 4);
      dn_rdata  = $urandom;
      @(negedge clk);
      model_eval();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if ({gnt_a[k], req_a[k], rv_a[k], spur_a[k]} !== {e_gnt[k], e_req[k], e_rv[k], mspur[k]} ||
            cnt_a[k] !== 3'(e_cnt[k])) begin
          n_fail++;
          $display("FAIL rand_ctrl[%0d] c%0d: gnt/req/rv/spur=%b%b%b%b cnt=%0d exp %b%b%b%b cnt=%0d",
                   k, c, gnt_a[k], req_a[k], rv_a[k], spur_a[k], cnt_a[k],
                   e_gnt[k], e_req[k], e_rv[k], mspur[k], e_cnt[k]);
        end
        if (e_rv[k] || rr[k]) begin
          n_chk++;
          if ({rid_a[k], rdata_a[k]} !== {e_rid[k], e_rdata[k]}) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d] c%0d: rid=%h rdata=%h exp %h %h",
                     k, c, rid_a[k], rdata_a[k], e_rid[k], e_rdata[k]);
          end
        end
      end
      @(posedge clk);
      model_step();
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_fill_and_drain();
    test_back_to_back_rspreg();
    test_full_simul_pop();
    test_spurious();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
